// File: rtl/display_pkg.sv
// Shared types and seven-segment constants for the display readout.
package display_pkg;

    // Converter phases: wait for a request, run the shifts, publish the result.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } disp_state_t;

    typedef logic [3:0] bcd_digit_t;

    // Active-low segments {g,f,e,d,c,b,a}; all ones turns the digit off.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digit-to-segment table, element 9 first so that SEG_DIGITS[d] selects digit d.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg7_encode.sv
// One BCD digit to active-low seven-segment pattern, with a forced-blank input.
module seg7_encode
    import display_pkg::*;
(
    input  bcd_digit_t  digit,
    input  logic        blank,
    output logic [6:0]  seg
);

    // Non-decimal nibbles cannot come out of the converter; show them as blank.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        seg = SEG_BLANK;
        if (!blank && digit <= 4'd9) begin
            seg = SEG_DIGITS[digit];
        end
    end

endmodule

// File: rtl/display_readout.sv
// Sequential double-dabble binary-to-BCD converter driving six paged HEX displays.
module display_readout
    import display_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    input  logic             page,
    input  logic             blank_zeros,
    output logic             busy,
    output logic             done,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [6:0]       hex4,
    output logic [6:0]       hex5
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int BCD_W = DIGITS * 4;

    disp_state_t      state_q, state_d;
    logic [WIDTH-1:0] bin_q;
    logic [BCD_W-1:0] acc_q;
    logic [BCD_W-1:0] acc_adj;
    logic [BCD_W-1:0] bcd_q;
    logic [CNT_W-1:0] cnt_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and status outputs; busy covers the whole conversion including DONE.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (load) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (cnt_q == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Add-3 correction: each nibble independently, no carry into its neighbour.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    // Conversion datapath; bcd_q only changes in DONE so the display holds the previous result.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the result register is reset too, so the displays come up showing a defined zero.
        if (!rst_n) begin
            bin_q <= '0;
            acc_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        bin_q <= value;
                        acc_q <= '0;
                        cnt_q <= CNT_W'(WIDTH - 1);
                    end
                end
                ST_SHIFT: begin
                    {acc_q, bin_q} <= {acc_adj[BCD_W-2:0], bin_q, 1'b0};
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                ST_DONE: begin
                    bcd_q <= acc_q;
                end
                default: ;
            endcase
        end
    end

    // Leading-zero suppression over the full number, scanned from the top digit down.
    logic [DIGITS-1:0] suppress;
    always_comb begin
        logic run;
        run      = 1'b1;
        suppress = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            run         = run && (bcd_q[4*i +: 4] == 4'd0);
            suppress[i] = blank_zeros && run && (i != 0);
        end
    end

    bcd_digit_t hex_digit [6];
    logic [5:0] hex_blank;
    logic [6:0] hex_seg   [6];

    // Page select: low six digits, or the top four right-aligned with hex5/hex4 dark.
    always_comb begin
        hex_blank = '1;
        for (int i = 0; i < 6; i++) hex_digit[i] = '0;
        if (!page) begin
            for (int i = 0; i < 6; i++) begin
                hex_digit[i] = bcd_q[4*i +: 4];
                hex_blank[i] = suppress[i];
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                hex_digit[i] = bcd_q[4*(i+6) +: 4];
                hex_blank[i] = suppress[i+6];
            end
        end
    end

    for (genvar g = 0; g < 6; g++) begin : g_seg
        seg7_encode u_seg (
            .digit (hex_digit[g]),
            .blank (hex_blank[g]),
            .seg   (hex_seg[g])
        );
    end

    assign hex0 = hex_seg[0];
    assign hex1 = hex_seg[1];
    assign hex2 = hex_seg[2];
    assign hex3 = hex_seg[3];
    assign hex4 = hex_seg[4];
    assign hex5 = hex_seg[5];

endmodule
